// File: rtl/fx2_ep_scheduler_if.sv
// FX2 slave-FIFO scheduler bus: flag pins and datapath handshake in, FIFOADR and grant out.
// master = the scheduler, slave = the FX2 flag pins plus the granted byte movers.
interface fx2_ep_scheduler_if;
    logic        usb_ep2_empty;
    logic        usb_ep4_empty;
    logic        usb_ep6_full;
    logic        usb_ep8_full;
    logic        dac_space_ok;
    logic        adc_data_ok;
    logic        cmd_pending;
    logic        xfer_byte;
    logic        xfer_done;
    logic [1:0]  usb_addr;
    logic [3:0]  grant;
    logic        grant_valid;
    logic [15:0] burst_count;

    modport master (
        input  usb_ep2_empty, usb_ep4_empty, usb_ep6_full, usb_ep8_full,
        input  dac_space_ok, adc_data_ok, cmd_pending, xfer_byte, xfer_done,
        output usb_addr, grant, grant_valid, burst_count
    );

    modport slave (
        output usb_ep2_empty, usb_ep4_empty, usb_ep6_full, usb_ep8_full,
        output dac_space_ok, adc_data_ok, cmd_pending, xfer_byte, xfer_done,
        input  usb_addr, grant, grant_valid, burst_count
    );
endinterface

// File: rtl/fx2_ep_scheduler.sv
// Round-robin arbiter for the FX2 slave-FIFO bus across EP2/EP4/EP6/EP8 with address settle
// and bounded bursts. Define FX2_SCHED_CMD_PRIO_EN to give EP4 commands absolute priority.
module fx2_ep_scheduler #(
    parameter int MAX_BURST     = 512,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    fx2_ep_scheduler_if.master    bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACTIVE,
        ST_RELEASE
    } state_t;

    localparam logic [16:0] BURST_LIMIT = 17'(MAX_BURST);
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  addr_q, addr_d;
    logic [1:0]  last_q, last_d;
    logic [3:0]  grant_q, grant_d;
    logic        grant_valid_q, grant_valid_d;
    logic [15:0] count_q, count_d;
    logic [3:0]  settle_q, settle_d;

    logic [3:0]  elig;
    logic [2:0]  pick;
    logic        burst_full;

    // First eligible endpoint after 'last', wrapping; result is {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] e, input logic [1:0] last);
        logic [2:0] r;
        logic [1:0] c;
        r = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            c = last + 2'(k);
            if (!r[2] && e[c]) begin
                r = {1'b1, c};
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    always_comb begin
        elig[0] = !bus.usb_ep2_empty && bus.dac_space_ok;
        elig[1] = !bus.usb_ep4_empty;
        elig[2] = !bus.usb_ep6_full && bus.adc_data_ok;
        elig[3] = !bus.usb_ep8_full && bus.cmd_pending;
    end

`ifdef FX2_SCHED_CMD_PRIO_EN
    always_comb begin
        if (elig[1]) begin
            pick = 3'b101;
        end else begin
            pick = rr_pick(elig & 4'b1101, last_q);
        end
    end
`else
    always_comb begin
        pick = rr_pick(elig, last_q);
    end
`endif

    // The byte on the limit cycle is counted, so compare against count+1.
    assign burst_full = bus.xfer_byte && (({1'b0, count_q} + 17'd1) == BURST_LIMIT);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        last_d        = last_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        count_d       = count_q;
        settle_d      = settle_q;

        case (state_q)
            ST_IDLE: begin
                if (pick[2]) begin
                    addr_d   = pick[1:0];
                    settle_d = 4'd0;
                    if (SETTLE_CYCLES == 0) begin
                        grant_d       = onehot(pick[1:0]);
                        grant_valid_d = 1'b1;
                        count_d       = 16'd0;
                        state_d       = ST_ACTIVE;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
            end

            ST_SETTLE: begin
                if (!elig[addr_q]) begin
                    state_d = ST_RELEASE;
                end else if (settle_q == SETTLE_LAST) begin
                    grant_d       = onehot(addr_q);
                    grant_valid_d = 1'b1;
                    count_d       = 16'd0;
                    state_d       = ST_ACTIVE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            ST_ACTIVE: begin
                if (bus.xfer_byte) begin
                    count_d = count_q + 16'd1;
                end
                if (burst_full || bus.xfer_done || !elig[addr_q]) begin
                    grant_d       = 4'b0000;
                    grant_valid_d = 1'b0;
                    state_d       = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
`ifdef FX2_SCHED_CMD_PRIO_EN
                if (addr_q != 2'd1) begin
                    last_d = addr_q;
                end
`else
                last_d = addr_q;
`endif
                state_d = ST_IDLE;
            end

            default: begin
                grant_d       = 4'b0000;
                grant_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= 2'd0;
            last_q        <= 2'd3;
            grant_q       <= 4'b0000;
            grant_valid_q <= 1'b0;
            count_q       <= 16'd0;
            settle_q      <= 4'd0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            last_q        <= last_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            count_q       <= count_d;
            settle_q      <= settle_d;
        end
    end

    assign bus.usb_addr    = addr_q;
    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.burst_count = count_q;

endmodule

// File: tb/tb_fx2_ep_scheduler.sv
// Bench for fx2_ep_scheduler: directed scenarios then randomized flag traffic, all cycles
// compared against a transaction-level arbitration model.
module tb_fx2_ep_scheduler;

    localparam int MAXB = 512;
    localparam int SETL = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fx2_ep_scheduler_if bus();

    fx2_ep_scheduler #(.MAX_BURST(MAXB), .SETTLE_CYCLES(SETL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_chk = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_busy, m_granted, m_cool;
    int m_sel, m_timer, m_last, m_addr, m_count;

    function automatic bit [3:0] elig_now();
        bit [3:0] e;
        e[0] = (bus.usb_ep2_empty === 1'b0) && (bus.dac_space_ok === 1'b1);
        e[1] = (bus.usb_ep4_empty === 1'b0);
        e[2] = (bus.usb_ep6_full === 1'b0) && (bus.adc_data_ok === 1'b1);
        e[3] = (bus.usb_ep8_full === 1'b0) && (bus.cmd_pending === 1'b1);
        return e;
    endfunction

    function automatic int next_ep(input bit [3:0] e, input int last);
`ifdef FX2_SCHED_CMD_PRIO_EN
        if (e[1]) return 1;
        for (int k = 1; k <= 4; k++) begin
            if (((last + k) % 4) != 1 && e[(last + k) % 4]) return (last + k) % 4;
        end
`else
        for (int k = 1; k <= 4; k++) begin
            if (e[(last + k) % 4]) return (last + k) % 4;
        end
`endif
        return -1;
    endfunction

    function automatic void finish_grant();
        m_granted = 1'b0;
        m_busy    = 1'b0;
        m_cool    = 1'b1;
`ifdef FX2_SCHED_CMD_PRIO_EN
        if (m_sel != 1) m_last = m_sel;
`else
        m_last = m_sel;
`endif
    endfunction

    always @(posedge clk) begin
        bit [3:0] e;
        int p;
        e = elig_now();
        if (reset) begin
            m_busy = 0; m_granted = 0; m_cool = 0;
            m_sel = 0; m_timer = 0; m_last = 3; m_addr = 0; m_count = 0;
        end else if (m_cool) begin
            m_cool = 0;
        end else if (!m_busy) begin
            p = next_ep(e, m_last);
            if (p >= 0) begin
                m_busy = 1; m_sel = p; m_addr = p; m_timer = SETL;
                if (m_timer == 0) begin
                    m_granted = 1; m_count = 0;
                end
            end
        end else if (!m_granted) begin
            if (!e[m_sel]) begin
                finish_grant();
            end else begin
                m_timer--;
                if (m_timer == 0) begin
                    m_granted = 1; m_count = 0;
                end
            end
        end else begin
            if (bus.xfer_byte) m_count++;
            if (m_count == MAXB || bus.xfer_done || !e[m_sel]) finish_grant();
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check_eq("grant", {28'd0, bus.grant}, m_granted ? (32'd1 << m_sel) : 32'd0);
            check_eq("grant_valid", {31'd0, bus.grant_valid}, {31'd0, m_granted});
            check_eq("usb_addr", {30'd0, bus.usb_addr}, 32'(m_addr));
            check_eq("burst_count", {16'd0, bus.burst_count}, 32'(m_count));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_elig(input bit e2, input bit e4, input bit e6, input bit e8);
        bus.usb_ep2_empty = !e2; bus.dac_space_ok = e2;
        bus.usb_ep4_empty = !e4;
        bus.usb_ep6_full  = !e6; bus.adc_data_ok  = e6;
        bus.usb_ep8_full  = !e8; bus.cmd_pending  = e8;
    endtask

    task automatic quiet();
        set_elig(0, 0, 0, 0);
        bus.xfer_byte = 0; bus.xfer_done = 0;
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_grant(input int limit, output int idx);
        int n;
        idx = -1; n = 0;
        while (bus.grant_valid && n < limit) begin @(negedge clk); n++; end
        while (!bus.grant_valid && n < limit) begin @(negedge clk); n++; end
        if (bus.grant_valid) begin
            for (int k = 0; k < 4; k++) if (bus.grant[k]) idx = k;
        end else begin
            check_eq("grant_timeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, hi, lo, n;
        int exp1[5];
        int exp6[4];
`ifdef FX2_SCHED_CMD_PRIO_EN
        exp1 = '{1, 1, 1, 1, 1};
        exp6 = '{1, 1, 1, 1};
`else
        exp1 = '{0, 1, 2, 3, 0};
        exp6 = '{0, 1, 0, 1};
`endif
        set_elig(0, 0, 0, 0);
        bus.xfer_byte = 0; bus.xfer_done = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_on = 1'b1;
        check_eq("rst_grant", {28'd0, bus.grant}, 32'd0);
        check_eq("rst_addr", {30'd0, bus.usb_addr}, 32'd0);
        check_eq("rst_count", {16'd0, bus.burst_count}, 32'd0);

        // all eligible, one-cycle bursts: round-robin order from EP2
        set_elig(1, 1, 1, 1);
        bus.xfer_done = 1;
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            wait_grant(40, g);
            check_eq($sformatf("t1_ep%0d", i), 32'(g), 32'(exp1[i]));
            check_eq($sformatf("t1_addr%0d", i), {30'd0, bus.usb_addr}, 32'(exp1[i]));
        end
        quiet();

        // EP2 alone, byte every cycle: forced release at MAX_BURST
        set_elig(1, 0, 0, 0);
        bus.xfer_byte = 1;
        wait_grant(40, g);
        check_eq("t2_ep", 32'(g), 32'd0);
        hi = 0;
        while (bus.grant_valid && hi < MAXB + 10) begin @(negedge clk); hi++; end
        check_eq("t2_hi_cycles", 32'(hi), 32'(MAXB));
        check_eq("t2_final_count", {16'd0, bus.burst_count}, 32'(MAXB));
        lo = 0;
        while (!bus.grant_valid && lo < 50) begin @(negedge clk); lo++; end
        check_eq("t2_gap", 32'(lo), 32'(2 + SETL));
        check_eq("t2_regrant", {28'd0, bus.grant}, 32'd1);
        quiet();

        // EP6 goes full on the same cycle as a byte: byte counted, then release
        set_elig(0, 0, 1, 0);
        wait_grant(40, g);
        check_eq("t3_ep", 32'(g), 32'd2);
        repeat (3) @(negedge clk);
        bus.usb_ep6_full = 1; bus.xfer_byte = 1;
        @(negedge clk);
        bus.xfer_byte = 0;
        check_eq("t3_grant", {28'd0, bus.grant}, 32'd0);
        check_eq("t3_count", {16'd0, bus.burst_count}, 32'd1);
        quiet();

        // EP8 loses eligibility during settle: no grant pulse, EP2 next
        set_elig(0, 0, 0, 1);
        n = 0;
        while (bus.usb_addr != 2'd3 && n < 20) begin @(negedge clk); n++; end
        check_eq("t4_addr", {30'd0, bus.usb_addr}, 32'd3);
        check_eq("t4_nogrant", {31'd0, bus.grant_valid}, 32'd0);
        set_elig(1, 0, 0, 0);
        wait_grant(40, g);
        check_eq("t4_next", 32'(g), 32'd0);
        quiet();

        // reset in the middle of a burst
        set_elig(1, 0, 0, 0);
        bus.xfer_byte = 1;
        wait_grant(40, g);
        n = 0;
        while (bus.burst_count != 16'd100 && n < 200) begin @(negedge clk); n++; end
        check_eq("t5_count100", {16'd0, bus.burst_count}, 32'd100);
        reset = 1;
        @(negedge clk);
        check_eq("t5_grant", {28'd0, bus.grant}, 32'd0);
        check_eq("t5_count", {16'd0, bus.burst_count}, 32'd0);
        check_eq("t5_addr", {30'd0, bus.usb_addr}, 32'd0);

        // EP2 and EP4 both eligible
        set_elig(1, 1, 0, 0);
        bus.xfer_byte = 0; bus.xfer_done = 1;
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            wait_grant(40, g);
            check_eq($sformatf("t6_ep%0d", i), 32'(g), 32'(exp6[i]));
        end

        // randomized flag traffic
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if ($urandom_range(11) == 0) bus.usb_ep2_empty = ~bus.usb_ep2_empty;
            if ($urandom_range(11) == 0) bus.usb_ep4_empty = ~bus.usb_ep4_empty;
            if ($urandom_range(11) == 0) bus.usb_ep6_full  = ~bus.usb_ep6_full;
            if ($urandom_range(11) == 0) bus.usb_ep8_full  = ~bus.usb_ep8_full;
            if ($urandom_range(11) == 0) bus.dac_space_ok  = ~bus.dac_space_ok;
            if ($urandom_range(11) == 0) bus.adc_data_ok   = ~bus.adc_data_ok;
            if ($urandom_range(11) == 0) bus.cmd_pending   = ~bus.cmd_pending;
            bus.xfer_byte = ($urandom_range(9) < 8);
            bus.xfer_done = ($urandom_range(39) == 0);
            reset = ($urandom_range(799) == 0);
        end
        reset = 0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
